hilo_acc: RTL



---
 rtl/hilo_acc_pkg.sv | 29 ++
 rtl/hilo_acc_if.sv | 26 ++
 rtl/hilo_acc_div_iter.sv | 52 +++++
 rtl/hilo_acc.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/hilo_acc_pkg.sv
// rtl/hilo_acc_pkg.sv - funct codes, divider FSM states and decoded op type for hilo_acc
package hilo_acc_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [5:0] F_MADD  = 6'h00;
    localparam logic [5:0] F_MADDU = 6'h01;
    localparam logic [5:0] F_MSUB  = 6'h04;
    localparam logic [5:0] F_MSUBU = 6'h05;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} div_state_t;

    typedef enum logic [3:0] {
        OP_NONE, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_MULT,
        OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
    } acc_op_t;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_acc_if.sv
// rtl/hilo_acc_if.sv - execute-stage request/response bundle for the HI/LO accumulator
interface hilo_acc_if;
    logic        ACCEn;
    logic        MULOp;
    logic        MULSelB;
    logic [5:0]  Func;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] MULout;
    logic [31:0] ACCout;
    logic        ACCO;
    logic        ACCZ;
    logic        ACCN;
    logic        ACCC;
    logic        Stall;

    modport master (
        output ACCEn, MULOp, MULSelB, Func, A, B, MULout,
        input  ACCout, ACCO, ACCZ, ACCN, ACCC, Stall
    );

    modport slave (
        input  ACCEn, MULOp, MULSelB, Func, A, B, MULout,
        output ACCout, ACCO, ACCZ, ACCN, ACCC, Stall
    );
endinterface

// File: rtl/hilo_acc_div_iter.sv
// rtl/hilo_acc_div_iter.sv - unsigned 32-bit restoring divider, one quotient bit per step
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;
    logic [32:0] shifted;
    logic [32:0] trial;

    // trial[32] is the borrow: set when the shifted remainder is below the divisor
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            if (!trial[32]) begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign done      = step && (cnt_q == 5'd31);
    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/hilo_acc.sv
// rtl/hilo_acc.sv - HI/LO registers, multiply-accumulate, flags, stall and iterative divide control
import hilo_acc_pkg::*;

module hilo_acc (
    input  logic      clk,
    input  logic      rst,
    hilo_acc_if.slave bus
);
    div_state_t  state_q, state_d;
    acc_op_t     op;
    logic [31:0] hi_q, lo_q;
    logic        neg_a_q, neg_b_q, by_zero_q;
    logic [63:0] acc, next_val;
    logic [64:0] sum, diff;
    logic        go, wr, start, div_signed, div_done;
    logic [31:0] out_w;
    logic        flag_o, flag_z, flag_n, flag_c;
    logic [31:0] quotient, remainder, q_fix, r_fix;

    // Move-to codes are only meaningful on the A source path (MULSelB low)
    always_comb begin
        op = OP_NONE;
        if (bus.ACCEn) begin
            if (bus.MULOp) begin
                case (bus.Func)
                    F_MADD:  op = OP_MADD;
                    F_MADDU: op = OP_MADDU;
                    F_MSUB:  op = OP_MSUB;
                    F_MSUBU: op = OP_MSUBU;
                    default: op = OP_NONE;
                endcase
            end else begin
                case (bus.Func)
                    F_MFHI:          op = OP_MFHI;
                    F_MFLO:          op = OP_MFLO;
                    F_MTHI:          op = bus.MULSelB ? OP_NONE : OP_MTHI;
                    F_MTLO:          op = bus.MULSelB ? OP_NONE : OP_MTLO;
                    F_MULT, F_MULTU: op = OP_MULT;
                    F_DIV:           op = OP_DIV;
                    F_DIVU:          op = OP_DIVU;
                    default:         op = OP_NONE;
                endcase
            end
        end
    end

    assign go        = (op != OP_NONE) && (state_q == IDLE);
    assign bus.Stall = (op != OP_NONE) && (state_q != IDLE);

    always_comb begin
        acc      = {hi_q, lo_q};
        sum      = {1'b0, acc} + {1'b0, bus.MULout};
        diff     = {1'b0, acc} - {1'b0, bus.MULout};
        next_val = acc;
        wr       = 1'b0;
        start    = 1'b0;
        out_w    = '0;
        flag_o   = 1'b0;
        flag_z   = 1'b0;
        flag_n   = 1'b0;
        flag_c   = 1'b0;
        if (go) begin
            case (op)
                OP_MFHI: begin out_w = hi_q; flag_z = (hi_q == '0); flag_n = hi_q[31]; end
                OP_MFLO: begin out_w = lo_q; flag_z = (lo_q == '0); flag_n = lo_q[31]; end
                OP_MTHI: begin next_val = {bus.A, lo_q}; wr = 1'b1; end
                OP_MTLO: begin next_val = {hi_q, bus.A}; wr = 1'b1; end
                OP_MULT: begin next_val = bus.MULout; wr = 1'b1; end
                OP_MADD, OP_MADDU: begin
                    next_val = sum[63:0];
                    wr       = 1'b1;
                    flag_c   = (op == OP_MADDU) && sum[64];
                    flag_o   = (op == OP_MADD) && (acc[63] == bus.MULout[63]) && (sum[63] != acc[63]);
                end
                OP_MSUB, OP_MSUBU: begin
                    next_val = diff[63:0];
                    wr       = 1'b1;
                    flag_c   = (op == OP_MSUBU) && diff[64];
                    flag_o   = (op == OP_MSUB) && (acc[63] != bus.MULout[63]) && (diff[63] != acc[63]);
                end
                OP_DIV, OP_DIVU: start = 1'b1;
                default: ;
            endcase
            if (wr) begin
                out_w  = next_val[31:0];
                flag_z = (next_val == '0);
                flag_n = next_val[63];
            end
        end
    end

    assign bus.ACCout = out_w;
    assign bus.ACCO   = flag_o;
    assign bus.ACCZ   = flag_z;
    assign bus.ACCN   = flag_n;
    assign bus.ACCC   = flag_c;

    assign div_signed = (op == OP_DIV);

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step      (state_q == BUSY),
        .dividend  (neg_if(bus.A, div_signed && bus.A[31])),
        .divisor   (neg_if(bus.B, div_signed && bus.B[31])),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // With a zero divisor the remainder is |A|, so the sign fix restores raw A into HI
    assign q_fix = by_zero_q ? 32'hFFFF_FFFF : neg_if(quotient, neg_a_q ^ neg_b_q);
    assign r_fix = neg_if(remainder, neg_a_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (div_done) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q      <= '0;
            lo_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            by_zero_q <= 1'b0;
        end else begin
            if (wr) begin
                hi_q <= next_val[63:32];
                lo_q <= next_val[31:0];
            end else if (state_q == FIX) begin
                hi_q <= r_fix;
                lo_q <= q_fix;
            end
            if (start) begin
                neg_a_q   <= div_signed && bus.A[31];
                neg_b_q   <= div_signed && bus.B[31];
                by_zero_q <= (bus.B == '0);
            end
        end
    end
endmodule
